// File: rtl/datapath_pkg.sv
// Shared types and constants for the microprogrammed execution datapath.
// Build option: DATAPATH_R0_ZERO_EN hardwires register 0 to zero.
package datapath_pkg;

    localparam int RF_DEPTH  = 8;
    localparam int RF_ADDR_W = 3;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic cy;
        logic neg;
        logic zero;
    } flags_t;

    function automatic alu_op_t to_alu_op(input logic [1:0] raw);
        return alu_op_t'(raw);
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational 2-bit-opcode ALU: add, subtract, and, pass-through.
// The carry is taken from a WIDTH+1 bit sum; logic ops clear it.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  alu_op_t          alu_op,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             negative,
    output logic             zero
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum   = '0;
        y     = '0;
        carry = 1'b0;
        unique case (alu_op)
            ALU_ADD: begin
                sum   = {1'b0, A} + {1'b0, B};
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            ALU_SUB: begin
                // carry set means no borrow, i.e. A >= B unsigned
                sum   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            ALU_AND: begin
                y = A & B;
            end
            ALU_PASS: begin
                y = A;
            end
        endcase
    end

    assign negative = y[WIDTH-1];
    assign zero     = (y == '0);

endmodule

// File: rtl/datapath.sv
// Execution datapath: 8-entry RF, ALU, R_in/R_out and registered flags.
// Build option: DATAPATH_R0_ZERO_EN makes RF[0] read as 0, ignore writes.
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RF_ADDR_W-1:0] fld_A,
    input  logic [RF_ADDR_W-1:0] fld_B,
    input  logic [RF_ADDR_W-1:0] fld_C,
    input  logic                 ldRF,
    input  logic                 selR_in,
    input  logic                 ldR_in,
    input  logic                 ldR_out,
    input  logic [1:0]           alu_op,
    input  logic [WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]     data_out,
    output logic                 out_valid,
    output logic                 cy,
    output logic                 neg,
    output logic                 zero
);

    logic [WIDTH-1:0] rf_q [RF_DEPTH];
    logic [WIDTH-1:0] rf_d [RF_DEPTH];
    logic [WIDTH-1:0] r_in_q, r_in_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             out_valid_q, out_valid_d;
    flags_t           flags_q, flags_d;

    logic [WIDTH-1:0] op_a, op_b, alu_y;
    logic             alu_cy, alu_neg, alu_zero;
    logic             wr_en;

    always_comb begin
        op_a = rf_q[fld_A];
        op_b = rf_q[fld_B];
`ifdef DATAPATH_R0_ZERO_EN
        if (fld_A == '0) op_a = '0;
        if (fld_B == '0) op_b = '0;
`endif
    end

    datapath_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .A        (op_a),
        .B        (op_b),
        .alu_op   (to_alu_op(alu_op)),
        .y        (alu_y),
        .carry    (alu_cy),
        .negative (alu_neg),
        .zero     (alu_zero)
    );

`ifdef DATAPATH_R0_ZERO_EN
    assign wr_en = ldRF && (fld_C != '0);
`else
    assign wr_en = ldRF;
`endif

    // Reads come from rf_q, so a same-cycle write is never forwarded.
    always_comb begin
        rf_d = rf_q;
        if (wr_en) rf_d[fld_C] = selR_in ? r_in_q : alu_y;
    end

    always_comb begin
        r_in_d      = ldR_in ? data_in : r_in_q;
        r_out_d     = ldR_out ? alu_y : r_out_q;
        out_valid_d = ldR_out;
        flags_d     = flags_q;
        if (ldR_out || (ldRF && !selR_in)) begin
            flags_d = '{cy: alu_cy, neg: alu_neg, zero: alu_zero};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
            r_in_q      <= '0;
            r_out_q     <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= '0;
        end else begin
            rf_q        <= rf_d;
            r_in_q      <= r_in_d;
            r_out_q     <= r_out_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
        end
    end

    assign data_out  = r_out_q;
    assign out_valid = out_valid_q;
    assign cy        = flags_q.cy;
    assign neg       = flags_q.neg;
    assign zero      = flags_q.zero;

endmodule
